// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets and
// bus handshake state encoding.
package clint_pkg;

    localparam logic [15:0] MsipAddr       = 16'h0000;
    localparam logic [15:0] SsipAddr       = 16'h0004;
    localparam logic [15:0] MtimecmpLoAddr = 16'h4000;
    localparam logic [15:0] MtimecmpHiAddr = 16'h4004;
    localparam logic [15:0] MtimeLoAddr    = 16'hBFF8;
    localparam logic [15:0] MtimeHiAddr    = 16'hBFFC;

    typedef enum logic {
        Idle = 1'b0,
        Ack  = 1'b1
    } clint_state_e;

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for the machine timer: emits a one-cycle tick every
// CLOCK_CYCLES_PER_TICK clocks, on the cycle the counter wraps.
module clint_tick_gen #(
    parameter int CLOCK_CYCLES_PER_TICK = 2
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CountW = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;
    localparam logic [CountW-1:0] LastCount = CountW'(CLOCK_CYCLES_PER_TICK - 1);

    logic [CountW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (count == LastCount) begin
            count <= '0;
        end else begin
            count <= count + CountW'(1);
        end
    end

    assign tick = (count == LastCount);

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: free-running mtime, mtimecmp and software interrupt
// pending bits behind a single-beat rd_en/wr_en/ack bus slave.
module clint_timer
    import clint_pkg::*;
#(
    parameter int DATA_SIZE             = 32,
    parameter int CLOCK_CYCLES_PER_TICK = 2,
    parameter int ADDR_SIZE             = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 ack,
    output logic                 msip,
    output logic                 ssip,
    output logic [63:0]          mtime,
    output logic [63:0]          mtimecmp
);

    localparam bit Is64 = (DATA_SIZE == 64);
    localparam logic [ADDR_SIZE-1:0] WordMask = ~ADDR_SIZE'(3);
    localparam logic [ADDR_SIZE-1:0] WideMask = Is64 ? ~ADDR_SIZE'(7) : ~ADDR_SIZE'(3);

    clint_state_e         state;
    logic                 tick;
    logic                 do_wr;
    logic [ADDR_SIZE-1:0] word_addr;
    logic [ADDR_SIZE-1:0] wide_addr;
    logic                 sel_msip, sel_ssip;
    logic                 sel_cmp_lo, sel_cmp_hi;
    logic                 sel_time_lo, sel_time_hi;
    logic [DATA_SIZE-1:0] rd_mux;

    clint_tick_gen #(
        .CLOCK_CYCLES_PER_TICK(CLOCK_CYCLES_PER_TICK)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // msip/ssip stay word-decoded even on a 64-bit bus so ssip remains reachable.
    assign word_addr   = addr & WordMask;
    assign wide_addr   = addr & WideMask;
    assign sel_msip    = (word_addr == ADDR_SIZE'(MsipAddr));
    assign sel_ssip    = (word_addr == ADDR_SIZE'(SsipAddr));
    assign sel_cmp_lo  = (wide_addr == ADDR_SIZE'(MtimecmpLoAddr));
    assign sel_cmp_hi  = !Is64 && (word_addr == ADDR_SIZE'(MtimecmpHiAddr));
    assign sel_time_lo = (wide_addr == ADDR_SIZE'(MtimeLoAddr));
    assign sel_time_hi = !Is64 && (word_addr == ADDR_SIZE'(MtimeHiAddr));

    assign do_wr = (state == Idle) && wr_en;

    always_comb begin
        rd_mux = '0;
        if (sel_msip) begin
            rd_mux = DATA_SIZE'(msip);
        end else if (sel_ssip) begin
            rd_mux = DATA_SIZE'(ssip);
        end else if (sel_cmp_lo) begin
            rd_mux = DATA_SIZE'(mtimecmp);
        end else if (sel_cmp_hi) begin
            rd_mux = DATA_SIZE'(mtimecmp[63:32]);
        end else if (sel_time_lo) begin
            rd_mux = DATA_SIZE'(mtime);
        end else if (sel_time_hi) begin
            rd_mux = DATA_SIZE'(mtime[63:32]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= Idle;
            ack      <= 1'b0;
            rd_data  <= '0;
            msip     <= 1'b0;
            ssip     <= 1'b0;
            mtimecmp <= '1;
        end else begin
            unique case (state)
                Idle: begin
                    if (rd_en || wr_en) begin
                        state   <= Ack;
                        ack     <= 1'b1;
                        rd_data <= wr_en ? '0 : rd_mux;
                    end
                end
                Ack: begin
                    state <= Idle;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= Idle;
                    ack   <= 1'b0;
                end
            endcase

            if (do_wr) begin
                if (sel_msip) msip <= wr_data[0];
                if (sel_ssip) ssip <= wr_data[0];
                if (sel_cmp_lo) begin
                    if (Is64) mtimecmp <= 64'(wr_data);
                    else      mtimecmp[31:0] <= 32'(wr_data);
                end
                if (sel_cmp_hi) mtimecmp[63:32] <= 32'(wr_data);
            end
        end
    end

    // A bus write to either half pre-empts that cycle's increment entirely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (do_wr && sel_time_lo) begin
            if (Is64) mtime <= 64'(wr_data);
            else      mtime[31:0] <= 32'(wr_data);
        end else if (do_wr && sel_time_hi) begin
            mtime[63:32] <= 32'(wr_data);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: transfers queue their expected read data,
// a negedge monitor pops and compares whenever ack is presented.
module tb_clint_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        ack;
    logic        msip;
    logic        ssip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    always #5 clock = ~clock;

    clint_timer #(
        .DATA_SIZE(32),
        .CLOCK_CYCLES_PER_TICK(2),
        .ADDR_SIZE(16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .ack     (ack),
        .msip    (msip),
        .ssip    (ssip),
        .mtime   (mtime),
        .mtimecmp(mtimecmp)
    );

    typedef struct {
        bit          chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] snap_mtime;
    logic [63:0] snap_cmp;
    logic        snap_msip;
    logic        snap_ssip;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got ack=1 with no transfer pending, expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) check64(e.name, 64'(rd_data), 64'(e.val));
            end
        end
    end

    // Called on a negedge; request seen at the next posedge, returns two negedges later.
    task automatic xfer(input bit r, input bit w, input logic [15:0] a, input logic [31:0] d,
                        input bit chk, input logic [31:0] exp, input string name);
        exp_t e;
        e.chk = chk;
        e.val = exp;
        e.name = name;
        sb.push_back(e);
        rd_en = r;
        wr_en = w;
        addr = a;
        wr_data = d;
        @(posedge clock);
        #1;
        check64({name, "_ack"}, 64'(ack), 64'd1);
        snap_mtime = mtime;
        snap_cmp = mtimecmp;
        snap_msip = msip;
        snap_ssip = ssip;
        @(negedge clock);
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check64({name, "_ack_low"}, 64'(ack), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clock);
        check64("rst_ack", 64'(ack), 64'd0);
        check64("rst_rd_data", 64'(rd_data), 64'd0);
        check64("rst_mtime", mtime, 64'd0);
        check64("rst_mtimecmp", mtimecmp, '1);
        reset = 1'b0;

        // Ten clocks at two clocks per tick.
        repeat (10) @(posedge clock);
        @(negedge clock);
        check64("idle_mtime", mtime, 64'd5);
        check64("idle_mtimecmp", mtimecmp, '1);
        check64("idle_msip", 64'(msip), 64'd0);
        check64("idle_ssip", 64'(ssip), 64'd0);
        xfer(1, 0, 16'hBFF8, 32'h0, 1, 32'd5, "rd_mtime_lo");

        // Software interrupt bits.
        xfer(0, 1, 16'h0000, 32'h1, 0, 32'h0, "wr_msip1");
        check64("msip_set", 64'(snap_msip), 64'd1);
        xfer(0, 1, 16'h0004, 32'h1, 0, 32'h0, "wr_ssip1");
        check64("ssip_set", 64'(snap_ssip), 64'd1);
        xfer(1, 0, 16'h0000, 32'h0, 1, 32'h1, "rd_msip");
        xfer(1, 0, 16'h0004, 32'h0, 1, 32'h1, "rd_ssip");
        xfer(0, 1, 16'h0000, 32'h0, 0, 32'h0, "wr_msip0");
        check64("msip_clr", 64'(snap_msip), 64'd0);
        check64("ssip_kept", 64'(snap_ssip), 64'd1);
        xfer(0, 1, 16'h0004, 32'h0, 0, 32'h0, "wr_ssip0");
        check64("ssip_clr", 64'(snap_ssip), 64'd0);

        // Compare register.
        xfer(0, 1, 16'h4000, 32'h5, 0, 32'h0, "wr_cmp_lo");
        check64("cmp_lo_port", snap_cmp, 64'hFFFF_FFFF_0000_0005);
        xfer(0, 1, 16'h4004, 32'h0, 0, 32'h0, "wr_cmp_hi");
        check64("cmp_port", snap_cmp, 64'd5);
        xfer(1, 0, 16'h4000, 32'h0, 1, 32'h5, "rd_cmp_lo");
        xfer(1, 0, 16'h4004, 32'h0, 1, 32'h0, "rd_cmp_hi");

        // Carry from low into high half.
        xfer(0, 1, 16'hBFFC, 32'h0, 0, 32'h0, "wr_mtime_hi");
        xfer(0, 1, 16'hBFF8, 32'hFFFF_FFFF, 0, 32'h0, "wr_mtime_lo");
        check64("mtime_lo_written", snap_mtime, 64'h0000_0000_FFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            if (mtime !== 64'h0000_0000_FFFF_FFFF) break;
            @(negedge clock);
        end
        check64("mtime_carry", mtime, 64'h0000_0001_0000_0000);

        // Now just after a tick edge; the request issued one negedge later lands on the next tick.
        @(negedge clock);
        xfer(0, 1, 16'hBFFC, 32'hA5A5_0000, 0, 32'h0, "wr_hi_on_tick");
        check64("hi_on_tick", snap_mtime, 64'hA5A5_0000_0000_0000);
        xfer(0, 1, 16'hBFF8, 32'h1234_5678, 0, 32'h0, "wr_lo_on_tick");
        check64("lo_on_tick", snap_mtime, 64'hA5A5_0000_1234_5678);
        xfer(1, 0, 16'hBFF8, 32'h0, 1, 32'h1234_5678, "rd_on_tick");
        check64("tick_after_rd", snap_mtime, 64'hA5A5_0000_1234_5679);
        xfer(1, 0, 16'hBFFC, 32'h0, 1, 32'hA5A5_0000, "rd_mtime_hi");

        // Unmapped read and simultaneous read/write.
        xfer(1, 0, 16'h2000, 32'h0, 1, 32'h0, "rd_unmapped");
        xfer(1, 1, 16'h0000, 32'h1, 1, 32'h0, "rd_wr_both");
        check64("both_msip", 64'(snap_msip), 64'd1);

        // Reset while acknowledging a write.
        wr_en = 1'b1;
        addr = 16'h4000;
        wr_data = 32'h0000_1111;
        @(posedge clock);
        #1;
        check64("pre_rst_ack", 64'(ack), 64'd1);
        check64("pre_rst_cmp", mtimecmp, 64'h0000_0000_0000_1111);
        #2;
        reset = 1'b1;
        #1;
        check64("mid_rst_ack", 64'(ack), 64'd0);
        check64("mid_rst_cmp", mtimecmp, '1);
        check64("mid_rst_msip", 64'(msip), 64'd0);
        @(negedge clock);
        wr_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check64("post_rst_cmp", mtimecmp, '1);
        check64("post_rst_ack", 64'(ack), 64'd0);
        check64("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
